uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8N1 serial frames from an asynchronous `rx_in` line and presents each byte with a one-cycle `rx_valid` strobe. It is the receiving end of the UART link whose transmit side is started by the button one-shot. It sits between the board RX pin and the downstream byte consumer (display/register logic). The block has a fixed 8 data bits, no parity, 1 stop bit, and samples at mid-bit using a clock-cycle counter (no oversampling tick).

## Interface
- `CLK_FREQ`, default 50_000_000, system clock frequency in Hz.
- `BAUD`, default 9600, line rate in bit/s.
- Derived constant `CPB = CLK_FREQ/BAUD` (integer division), clocks per bit. It must satisfy `CPB >= 4`.
- Derived constant `HALF = CPB/2` (floor).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_in`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  8  last correctly received byte; holds its value between frames.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` has been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx_in` passes through a 2-FF synchronizer reset to 1, producing `rx_s`. The synchronizer introduces 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rx_s` is 0, go to START and clear the counter and bit index.
- START: when counter reaches `HALF-1`, sample `rx_s`.
  - If 0, this is a valid start bit: go to DATA and clear the counter.
  - If 1, this is a glitch: return to IDLE with no output pulse.
- DATA: when counter reaches `CPB-1`, shift `rx_s` into the shift register LSB-first and clear the counter. After bit index 7, go to STOP.
- STOP: when counter reaches `CPB-1`, sample `rx_s`.
  - If 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE. The FSM re-arms at mid-stop bit, so back-to-back frames are accepted.
  - If 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This state handles a break or stuck-low line.
- Reset values: `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `busy` = 0. The FSM resets to IDLE, the counter and shift register to 0, and both synchronizer stages to 1.
- Reset has priority over all events, including mid-frame. A partially received byte is discarded, and no pulse is emitted in the cycle after reset.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Cycle 0 is the edge on which IDLE sees `rx_s` = 0. The falling edge on the pin precedes cycle 0 by 2 cycles.
- Start check occurs at cycle `HALF`.
- Data bit k (k = 0..7) is sampled at cycle `HALF + (k+1)*CPB`.
- Stop bit is sampled at cycle `HALF + 9*CPB`. `rx_valid` or `frame_err` is high for exactly the following cycle. `rx_data` is valid on that same cycle and remains stable until the next `rx_valid`.
- `busy` rises on cycle 1 and falls on the cycle in which `rx_valid` is high, or on the cycle after WAIT_HIGH exits.
- A new start edge can be detected as early as the cycle after the stop sample.
- Counter width is `$clog2(CPB)`. The counter is never compared against values of `CPB` or greater.

## Structure
- Shared package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the frame constants `DATA_BITS` = 8 and `STOP_BITS` = 1;
  - a `clks_per_bit(clk_freq, baud)` function, reused by the transmitter.
- One sub-module: `sync_2ff` (1-bit, reset value parameterized). It is shared with other asynchronous inputs such as the button path.

## Test plan
Run with `CLK_FREQ` = 16 and `BAUD` = 1, so `CPB` = 16 and `HALF` = 8.
- **Reset:** `rst` high for 3 cycles, `rx_in` = 1. Expect `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `busy` = 0.
- **Single frame 0x55:** expect exactly one `rx_valid` pulse at cycle 153 relative to cycle 0 (2 cycles after the pin edge is cycle 0), with `rx_data` = 8'h55 and no `frame_err`.
- **Back-to-back 0xA3 then 0x0F, no idle gap:** expect two `rx_valid` pulses exactly 160 cycles apart, with data 8'hA3 then 8'h0F.
- **Glitch:** `rx_in` low for 4 cycles, then high. Expect no pulses and `busy` back to 0 by cycle 9. A following 0x3C frame is received correctly.
- **Framing error:** send 0xFF with the stop bit low and the line held low 40 more cycles. Expect one `frame_err` pulse, `rx_data` unchanged, `busy` high until the line returns high. A following 0x12 frame is received correctly.
- **Reset mid-frame:** assert `rst` during data bit 3. Expect outputs at reset values the next cycle and no pulse. A subsequent 0x81 frame yields `rx_data` = 8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame shape and the
// clocks-per-bit helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit period; integer division, so the bit time rounds down.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (UART RX) and idle-low lines can share it.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops before anyone uses it.
    // NOTE: both stages use non-blocking assignments so q takes the old meta;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at its middle using a clock-cycle
// counter, emits rx_valid for a good stop bit and frame_err for a low one.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);

    // Compare targets sized to the counter; both are below CPB so they fit.
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // The line idles high, so the synchronizer resets to 1 to avoid a
    // false start bit straight out of reset.
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_in),
        .q  (rx_s)
    );

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register, shift register included, is reset so a
            // frame cut short by reset cannot leak bits into the next byte.
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end

                // Recheck the line half a bit in; a high line means a glitch.
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // One full bit period between samples keeps us at mid-bit.
                DATA: begin
                    if (cnt == CPB_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Returning to IDLE at mid-stop lets back-to-back frames in.
                STOP: begin
                    if (cnt == CPB_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Break or stuck-low line: wait for it to idle before rearming.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB = 16: table-driven frames, directed
// corner sequences and randomized frames checked against a timing model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int SYNC_LAT = 2;
    // Bench cycle stamp (cyc at the negedge) of a pulse, relative to the
    // first clock edge that samples the start bit on the pin. Cycle 0 is
    // SYNC_LAT edges later; the pulse is in cycle HALF + 9*CPB + 1, which is
    // stamped one less because cyc counts edges already taken.
    localparam int PULSE_OFS = SYNC_LAT + HALF + (DATA_BITS + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int unstable = 0;
    logic [7:0] prev_data;
    logic [7:0] last_good;

    typedef struct {
        logic       kind;   // 0 = rx_valid, 1 = frame_err
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        logic       exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Record every output pulse and watch rx_data for changes without rx_valid.
    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            check("pulse exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
            got_q.push_back('{kind: frame_err, data: rx_data, cyc: cyc});
        end
        if (!rst && !rx_valid && rx_data !== prev_data) unstable++;
        prev_data = rx_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx_in = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    // Drive start, 8 data bits LSB first and the stop bit; returns the stamp
    // of the first edge that samples the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int edge_cyc);
        @(posedge clk);
        #1 rx_in = 1'b0;
        edge_cyc = cyc + 1;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    // Model: a frame yields one pulse PULSE_OFS after its start edge; a good
    // stop bit delivers the byte, a bad one leaves the last good byte.
    task automatic expect_frame(input int edge_cyc, input logic [7:0] d, input logic stop);
        exp_q.push_back('{kind: !stop, data: stop ? d : last_good, cyc: edge_cyc + PULSE_OFS});
        if (stop) last_good = d;
    endtask

    task automatic release_line(input int hold);
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1 rx_in = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        ev_t e;
        ev_t g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " pulse present"}, {31'b0, got_q.size() > 0}, 32'd1);
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                check({tag, " kind"}, {31'b0, g.kind}, {31'b0, e.kind});
                check({tag, " data"}, {24'b0, g.data}, {24'b0, e.data});
                check({tag, " cycle"}, g.cyc, e.cyc);
            end
        end
        check({tag, " extra pulses"}, got_q.size(), 32'd0);
        got_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int e1;
        int e2;
        int vp;
        int hold;
        int gap;
        logic [7:0] d;
        logic st;

        vecs[0] = '{8'h55, 1'b1, 0,  1'b0, 8'h55};
        vecs[1] = '{8'hFF, 1'b0, 40, 1'b1, 8'h55};
        vecs[2] = '{8'h12, 1'b1, 0,  1'b0, 8'h12};
        vecs[3] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
        vecs[4] = '{8'h80, 1'b0, 5,  1'b1, 8'h00};
        vecs[5] = '{8'h7E, 1'b1, 0,  1'b0, 8'h7E};

        // Reset: three cycles with the line idle.
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rx_data", {24'b0, rx_data}, 32'h00);
        check("reset rx_valid", {31'b0, rx_valid}, 32'd0);
        check("reset frame_err", {31'b0, frame_err}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        repeat (4) @(posedge clk);

        // Table-driven frames, one pulse each.
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            send_frame(vecs[i].data, vecs[i].stop, e1);
            if (!vecs[i].stop) release_line(vecs[i].hold);
            wait_cyc(e1 + PULSE_OFS + 2);
            check("table pulse count", got_q.size(), 32'd1);
            if (got_q.size() > 0) begin
                check("table kind", {31'b0, got_q[0].kind}, {31'b0, vecs[i].exp_kind});
                check("table data", {24'b0, got_q[0].data}, {24'b0, vecs[i].exp_data});
                check("table cycle", got_q[0].cyc, e1 + PULSE_OFS);
            end
            got_q.delete();
            repeat (4) @(posedge clk);
        end
        last_good = 8'h7E;

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, 1'b1, e1);
        send_frame(8'h0F, 1'b1, e2);
        expect_frame(e1, 8'hA3, 1'b1);
        expect_frame(e2, 8'h0F, 1'b1);
        wait_cyc(e2 + PULSE_OFS + 2);
        check("b2b pulse count", got_q.size(), 32'd2);
        if (got_q.size() >= 2) check("b2b spacing", got_q[1].cyc - got_q[0].cyc, 32'd160);
        compare_events("b2b");
        repeat (4) @(posedge clk);

        // Glitch: four low cycles on the pin must not start a frame.
        @(posedge clk);
        #1 rx_in = 1'b0;
        e1 = cyc + 1;
        repeat (4) @(posedge clk);
        #1 rx_in = 1'b1;
        wait_cyc(e1 + SYNC_LAT + 4);
        check("glitch busy during", {31'b0, busy}, 32'd1);
        wait_cyc(e1 + SYNC_LAT + 8);
        check("glitch busy cleared", {31'b0, busy}, 32'd0);
        repeat (10) @(posedge clk);
        compare_events("glitch");
        send_frame(8'h3C, 1'b1, e1);
        expect_frame(e1, 8'h3C, 1'b1);
        wait_cyc(e1 + PULSE_OFS + 2);
        compare_events("after glitch");
        repeat (4) @(posedge clk);

        // Framing error with the line held low 40 more cycles.
        send_frame(8'hFF, 1'b0, e1);
        expect_frame(e1, 8'hFF, 1'b0);
        repeat (40) @(posedge clk);
        #1 rx_in = 1'b1;
        vp = cyc;
        wait_cyc(vp + 2);
        check("ferr busy held", {31'b0, busy}, 32'd1);
        check("ferr rx_data kept", {24'b0, rx_data}, 32'h3C);
        wait_cyc(vp + 3);
        check("ferr busy released", {31'b0, busy}, 32'd0);
        compare_events("ferr");
        repeat (4) @(posedge clk);
        send_frame(8'h12, 1'b1, e1);
        expect_frame(e1, 8'h12, 1'b1);
        wait_cyc(e1 + PULSE_OFS + 2);
        compare_events("after ferr");
        repeat (4) @(posedge clk);

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int n = 0; n < 14; n++) begin
            d = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            send_frame(d, st, e1);
            expect_frame(e1, d, st);
            if (!st) begin
                hold = $urandom_range(0, 30);
                release_line(hold);
                gap = 4 + $urandom_range(0, 10);
            end else begin
                gap = $urandom_range(0, 12);
            end
            repeat (gap) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        compare_events("random");

        // Reset during data bit 3 of a frame.
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        d = 8'hC5;
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        @(posedge clk);
        #1 rx_in = d[3];
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset rx_data", {24'b0, rx_data}, 32'h00);
        check("midreset rx_valid", {31'b0, rx_valid}, 32'd0);
        check("midreset frame_err", {31'b0, frame_err}, 32'd0);
        check("midreset busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        repeat (20) @(posedge clk);
        compare_events("midreset quiet");
        send_frame(8'h81, 1'b1, e1);
        expect_frame(e1, 8'h81, 1'b1);
        wait_cyc(e1 + PULSE_OFS + 2);
        compare_events("after midreset");
        check("final rx_data", {24'b0, rx_data}, 32'h81);
        check("rx_data stable between pulses", unstable, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
